// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: FSM state type and port index constants shared by the data-memory arbiter
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_P0, GRANT_P1} state_t;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: next-grant decision (lock hold, then tie-break, then single requester)
// Ports: state = current grant state, req/lock per port, lock_max = lock run exhausted,
//        last_gnt = most recently granted port (round-robin build only), next = next state.
// Macro DMEM_ARB_FIXED_PRIO_EN: ties always go to p0 and last_gnt is not present.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  state_t state,
  input  logic   req_p0,
  input  logic   req_p1,
  input  logic   lock_p0,
  input  logic   lock_p1,
  input  logic   lock_max,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic   last_gnt,
`endif
  output state_t next
);
  logic tie;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie = P0;
`else
  assign tie = (last_gnt == P1) ? P0 : P1;
`endif
  assign next = (state == GRANT_P0 && req_p0 && lock_p0 && !lock_max) ? GRANT_P0 :
                (state == GRANT_P1 && req_p1 && lock_p1 && !lock_max) ? GRANT_P1 :
                (req_p0 && req_p1) ? ((tie == P0) ? GRANT_P0 : GRANT_P1) :
                req_p0 ? GRANT_P0 :
                req_p1 ? GRANT_P1 : IDLE;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core p0, debug/DMA p1) arbiter for a single-ported data memory
// Ports: clk, rst (async active-low); per port req/we/lock/addr/wdata in, gnt/rvalid out;
//        shared rdata; memory side mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (1-cycle latency).
// Macro DMEM_ARB_FIXED_PRIO_EN: fixed p0 priority on ties instead of round-robin.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 32,
  parameter int Max_Lock   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_p0,
  input  logic                  req_p1,
  input  logic                  we_p0,
  input  logic                  we_p1,
  input  logic                  lock_p0,
  input  logic                  lock_p1,
  input  logic [Addr_Width-1:0] addr_p0,
  input  logic [Addr_Width-1:0] addr_p1,
  input  logic [Data_Width-1:0] wdata_p0,
  input  logic [Data_Width-1:0] wdata_p1,
  output logic                  gnt_p0,
  output logic                  gnt_p1,
  output logic                  rvalid_p0,
  output logic                  rvalid_p1,
  output logic [Data_Width-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [Addr_Width-1:0] mem_addr,
  output logic [Data_Width-1:0] mem_wdata,
  input  logic [Data_Width-1:0] mem_rdata
);
  localparam int CW = $clog2(Max_Lock + 1);
  state_t state, next;
  logic [CW-1:0] lock_cnt;
  logic lock_max;
  assign lock_max = lock_cnt == CW'(Max_Lock);
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic last_gnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_gnt <= P1;
    else if (next != IDLE) last_gnt <= (next == GRANT_P1) ? P1 : P0;
`endif
  dmem_arb_pick u_pick (
    .state(state),
    .req_p0(req_p0),
    .req_p1(req_p1),
    .lock_p0(lock_p0),
    .lock_p1(lock_p1),
    .lock_max(lock_max),
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .last_gnt(last_gnt),
`endif
    .next(next)
  );
  // lock_cnt is the length of the current run of grants to one port; a run that
  // reached Max_Lock restarts at 1 so the lock is ignored for one arbitration only
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      rvalid_p0 <= 1'b0;
      rvalid_p1 <= 1'b0;
    end else begin
      state     <= next;
      lock_cnt  <= (next == IDLE) ? '0 : (next == state && !lock_max) ? lock_cnt + CW'(1) : CW'(1);
      rvalid_p0 <= state == GRANT_P0 && !we_p0;
      rvalid_p1 <= state == GRANT_P1 && !we_p1;
    end
  always_comb begin
    gnt_p0    = state == GRANT_P0;
    gnt_p1    = state == GRANT_P1;
    mem_en    = gnt_p0 || gnt_p1;
    mem_we    = gnt_p0 ? we_p0 : gnt_p1 ? we_p1 : 1'b0;
    mem_addr  = gnt_p0 ? addr_p0 : gnt_p1 ? addr_p1 : '0;
    mem_wdata = gnt_p0 ? wdata_p0 : gnt_p1 ? wdata_p1 : '0;
    rdata     = (rvalid_p0 || rvalid_p1) ? mem_rdata : '0;
  end
endmodule
